// File: rtl/pending_encoder32to5.sv
// ---------------------------------------------------------------------------
// pending_encoder32to5
//
// Purpose:
//    Collects 32 request lines into a sticky pending register and offers the
//    lowest pending index to a consumer over a valid/ready handshake. A bit
//    stays pending until its handshake completes. Once an index is offered it
//    stays stable until accepted, even if a lower-index request arrives.
//    A request to an already-pending source sets a one-cycle collision pulse
//    and is merged into the existing entry.
//
// Ports:
//    clk          in   rising-edge clock for all state
//    reset        in   asynchronous active-high clear of all state
//    enable       in   1 = sample req on this edge, 0 = ignore req
//    req[31:0]    in   request lines, bit i = source i
//    out_ready    in   consumer accepts out_idx on this edge
//    out_valid    out  out_idx holds a pending source (registered)
//    out_idx[4:0] out  binary index of the offered source (registered)
//    pending[31:0]out  current pending register
//    collision    out  one-cycle pulse on a request to an already-pending source
//    grant_count  out  16-bit wrapping count of completed handshakes
// ---------------------------------------------------------------------------
module pending_encoder32to5 (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] req,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [4:0]  out_idx,
   output logic [31:0] pending,
   output logic        collision,
   output logic [15:0] grant_count
);

   logic [31:0] pending_q, pending_d;
   logic        valid_q, valid_d;
   logic [4:0]  idx_q, idx_d;
   logic        collision_q, collision_d;
   logic [15:0] grantCount_q, grantCount_d;

   logic        hs;
   logic [31:0] cap;
   logic [31:0] clr;
   logic [4:0]  lowIdx;

   // The handshake clears the offered bit. A capture on that same bit
   // re-sets it, so a re-arm keeps the source pending. It does not count as
   // a collision because the old entry is being retired on this edge.
   always_comb begin
      hs          = valid_q & out_ready;
      cap         = enable ? req : 32'h0;
      clr         = hs ? (32'h1 << idx_q) : 32'h0;
      pending_d   = (pending_q & ~clr) | cap;
      collision_d = |(cap & pending_q & ~clr);
   end

   // Priority encoder for the lowest set bit of the next pending value.
   // The loop scans from the top down so that the last hit is the lowest bit.
   always_comb begin
      lowIdx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (pending_d[i]) begin
            lowIdx = 5'(i);
         end
      end
   end

   // A new offer is chosen only when idle or when the current offer is being
   // accepted. While stalled, the offer is held so the consumer sees a stable
   // index. When nothing is pending, the old index is kept.
   always_comb begin
      valid_d      = valid_q;
      idx_d        = idx_q;
      grantCount_d = grantCount_q + {15'd0, hs};
      if (!valid_q || hs) begin
         valid_d = |pending_d;
         if (|pending_d) begin
            idx_d = lowIdx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q    <= 32'h0;
         valid_q      <= 1'b0;
         idx_q        <= 5'd0;
         collision_q  <= 1'b0;
         grantCount_q <= 16'd0;
      end else begin
         pending_q    <= pending_d;
         valid_q      <= valid_d;
         idx_q        <= idx_d;
         collision_q  <= collision_d;
         grantCount_q <= grantCount_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_idx     = idx_q;
   assign pending     = pending_q;
   assign collision   = collision_q;
   assign grant_count = grantCount_q;

endmodule

// File: tb/tb_pending_encoder32to5.sv
// ---------------------------------------------------------------------------
// tb_pending_encoder32to5
//
// Directed testbench for pending_encoder32to5. Each vector is driven on the
// falling edge. Results are sampled 1 time unit after the following rising
// edge. Expected values are constants worked out by hand from the design's
// intended behaviour.
// ---------------------------------------------------------------------------
module tb_pending_encoder32to5;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [31:0] req;
   logic        out_ready;
   logic        out_valid;
   logic [4:0]  out_idx;
   logic [31:0] pending;
   logic        collision;
   logic [15:0] grant_count;

   int vectorCount;
   int missCount;

   pending_encoder32to5 dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req         (req),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_idx     (out_idx),
      .pending     (pending),
      .collision   (collision),
      .grant_count (grant_count)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the observed and expected
   // values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs on the falling edge. It then waits until
   // just after the next rising edge, so the caller samples settled outputs.
   task automatic applyStimulus(input logic en, input logic [31:0] r, input logic rdy);
      @(negedge clk);
      enable    = en;
      req       = r;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectorCount = 0;
      missCount   = 0;
      reset       = 1'b1;
      enable      = 1'b0;
      req         = 32'h0;
      out_ready   = 1'b0;

      // Reset state
      #12;
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_idx", {27'd0, out_idx}, 32'd0);
      checkOutput("rst_pending", pending, 32'h0);
      checkOutput("rst_grant", {16'd0, grant_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Single request, one-cycle latency
      applyStimulus(1'b1, 32'h0000_0100, 1'b1);
      checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("single_idx", {27'd0, out_idx}, 32'd8);
      checkOutput("single_grant0", {16'd0, grant_count}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("single_valid_drop", {31'd0, out_valid}, 32'd0);
      checkOutput("single_grant1", {16'd0, grant_count}, 32'd1);
      checkOutput("single_pending", pending, 32'h0);

      // Multi-hot drain, back to back
      applyStimulus(1'b1, 32'h8000_0011, 1'b1);
      checkOutput("drain_idx0", {27'd0, out_idx}, 32'd0);
      checkOutput("drain_pend0", pending, 32'h8000_0011);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("drain_idx4", {27'd0, out_idx}, 32'd4);
      checkOutput("drain_valid4", {31'd0, out_valid}, 32'd1);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("drain_idx31", {27'd0, out_idx}, 32'd31);
      checkOutput("drain_pend31", pending, 32'h8000_0000);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("drain_pend_end", pending, 32'h0);
      checkOutput("drain_valid_end", {31'd0, out_valid}, 32'd0);
      checkOutput("drain_grant", {16'd0, grant_count}, 32'd4);

      // Stall stability: a lower index arriving must not displace the offer
      applyStimulus(1'b1, 32'h0000_0020, 1'b0);
      checkOutput("stall_idx5", {27'd0, out_idx}, 32'd5);
      applyStimulus(1'b1, 32'h0000_0004, 1'b0);
      checkOutput("stall_hold_idx", {27'd0, out_idx}, 32'd5);
      checkOutput("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_pending", pending, 32'h0000_0024);
      checkOutput("stall_no_coll", {31'd0, collision}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("stall_next_idx2", {27'd0, out_idx}, 32'd2);
      checkOutput("stall_pend_after", pending, 32'h0000_0004);
      checkOutput("stall_grant", {16'd0, grant_count}, 32'd5);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("stall_drained", {31'd0, out_valid}, 32'd0);
      checkOutput("stall_grant2", {16'd0, grant_count}, 32'd6);

      // Collision while pending, then re-arm on handshake
      applyStimulus(1'b1, 32'h0000_0080, 1'b0);
      checkOutput("coll_first", {31'd0, collision}, 32'd0);
      applyStimulus(1'b1, 32'h0000_0080, 1'b0);
      checkOutput("coll_pulse", {31'd0, collision}, 32'd1);
      checkOutput("coll_merged", pending, 32'h0000_0080);
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("coll_clear", {31'd0, collision}, 32'd0);
      applyStimulus(1'b1, 32'h0000_0080, 1'b1);
      checkOutput("rearm_no_coll", {31'd0, collision}, 32'd0);
      checkOutput("rearm_pending", pending, 32'h0000_0080);
      checkOutput("rearm_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("rearm_idx", {27'd0, out_idx}, 32'd7);
      checkOutput("rearm_grant", {16'd0, grant_count}, 32'd7);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("rearm_drained", {31'd0, out_valid}, 32'd0);
      checkOutput("rearm_grant2", {16'd0, grant_count}, 32'd8);

      // Enable gating; out_ready while idle must not change anything
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b1);
         checkOutput("gate_pending", pending, 32'h0);
         checkOutput("gate_valid", {31'd0, out_valid}, 32'd0);
      end
      checkOutput("gate_grant", {16'd0, grant_count}, 32'd8);

      // Asynchronous reset mid-offer
      applyStimulus(1'b1, 32'h0F0F_0000, 1'b0);
      checkOutput("ar_pending", pending, 32'h0F0F_0000);
      checkOutput("ar_idx", {27'd0, out_idx}, 32'd16);
      enable    = 1'b0;
      req       = 32'h0;
      out_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_now_pending", pending, 32'h0);
      checkOutput("ar_now_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("ar_now_idx", {27'd0, out_idx}, 32'd0);
      checkOutput("ar_now_coll", {31'd0, collision}, 32'd0);
      checkOutput("ar_now_grant", {16'd0, grant_count}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("ar_held_grant", {16'd0, grant_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("post_rst_pending", pending, 32'h0);
      applyStimulus(1'b1, 32'h0000_0002, 1'b0);
      checkOutput("post_rst_idx", {27'd0, out_idx}, 32'd1);
      checkOutput("post_rst_valid2", {31'd0, out_valid}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
